// File: rtl/riscv_imm_pkg.sv
// Shared immediate-format definitions for the RISC-V core's sign-extender and the
// test/boot instruction encoder.
package riscv_imm_pkg;

   // Same code as the sign-extender's src select.
   typedef enum logic [1:0] {
      FMT_I = 2'b00,
      FMT_S = 2'b01,
      FMT_B = 2'b10,
      FMT_J = 2'b11
   } fmt_e;

   localparam int IMM12_MIN = -2048;
   localparam int IMM12_MAX = 2047;
   localparam int IMMB_MIN  = -4096;
   localparam int IMMB_MAX  = 4094;
   localparam int IMMJ_MIN  = -1048576;
   localparam int IMMJ_MAX  = 1048574;

   localparam int unsigned WORD_W = 33;

   typedef struct packed {
      logic        err;
      logic [31:0] instr;
   } enc_word_t;

   function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bundle of the instruction encoder: field-level request in,
// encoded word out, plus saturating status counters.
interface imm_encoder_if #(
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_src;
   logic [6:0]       in_opcode;
   logic [2:0]       in_funct3;
   logic [4:0]       in_rd;
   logic [4:0]       in_rs1;
   logic [4:0]       in_rs2;
   logic [31:0]      in_imm;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic             out_err;
   logic [CNT_W-1:0] enc_count;
   logic [CNT_W-1:0] err_count;

   // Encoder side.
   modport slave (
      input  in_valid, in_src, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
      input  out_ready,
      output in_ready, out_valid, out_instr, out_err, enc_count, err_count
   );

   // Requester / loader side.
   modport master (
      output in_valid, in_src, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
      output out_ready,
      input  in_ready, out_valid, out_instr, out_err, enc_count, err_count
   );

endinterface

// File: rtl/instr_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra bit to tell full from empty.
module instr_fifo #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wptr_q, rptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Head reads as zero when empty so nothing stale is ever visible.
   assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/imm_encoder.sv
// Packs field-level RISC-V instruction requests into 32-bit words, range-checking the
// immediate, and buffers {err, instr} for the program-memory loader.
module imm_encoder
   import riscv_imm_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 16
) (
   input logic          clk,
   input logic          rst_n,
   imm_encoder_if.slave bus
);

   logic signed [31:0] simm;
   logic [31:0]        imm;
   logic [31:0]        enc_instr;
   logic               imm_ok;
   enc_word_t          wword, head;
   logic               fifo_full, fifo_empty;
   logic               push, pop;
   logic [CNT_W-1:0]   enc_q, err_q;

   assign imm  = bus.in_imm;
   assign simm = $signed(bus.in_imm);

   // Inverse of the sign-extender: scatter immediate bits into the format's slots.
   always_comb begin
      enc_instr = '0;
      imm_ok    = 1'b0;
      unique case (fmt_e'(bus.in_src))
         FMT_I: begin
            enc_instr = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            imm_ok    = in_range(simm, IMM12_MIN, IMM12_MAX);
         end
         FMT_S: begin
            enc_instr = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0],
                         bus.in_opcode};
            imm_ok    = in_range(simm, IMM12_MIN, IMM12_MAX);
         end
         FMT_B: begin
            enc_instr = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         imm[4:1], imm[11], bus.in_opcode};
            imm_ok    = in_range(simm, IMMB_MIN, IMMB_MAX) && !imm[0];
         end
         FMT_J: begin
            enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
            imm_ok    = in_range(simm, IMMJ_MIN, IMMJ_MAX) && !imm[0];
         end
         default: begin
            enc_instr = '0;
            imm_ok    = 1'b0;
         end
      endcase
   end

   assign wword.err   = !imm_ok;
   assign wword.instr = enc_instr;

   // in_ready comes from registered occupancy only; no same-cycle pass-through when full.
   assign push = bus.in_valid && !fifo_full;
   assign pop  = bus.out_ready && !fifo_empty;

   instr_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (wword),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.in_ready  = !fifo_full;
   assign bus.out_valid = !fifo_empty;
   assign bus.out_instr = head.instr;
   assign bus.out_err   = head.err;

   // Saturating status counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_q <= '0;
         err_q <= '0;
      end else if (push) begin
         if (enc_q != '1) enc_q <= enc_q + 1'b1;
         if (wword.err && (err_q != '1)) err_q <= err_q + 1'b1;
      end
   end

   assign bus.enc_count = enc_q;
   assign bus.err_count = err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vectors, backpressure, mid-stream reset,
// random round-trip through a sign-extender model, and counter saturation.
module tb_imm_encoder;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   imm_encoder_if #(.CNT_W(16)) ifc ();
   imm_encoder_if #(.CNT_W(4))  sat ();

   imm_encoder #(.FIFO_DEPTH(4), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
   imm_encoder #(.FIFO_DEPTH(4), .CNT_W(4)) u_sat (.clk(clk), .rst_n(rst_n), .bus(sat));

   typedef struct {
      logic [32:0] word;
      logic [31:0] imm;
      logic [1:0]  src;
      bit          rt;
   } sb_t;

   sb_t sb[$];
   int  vectors     = 0;
   int  miscompares = 0;
   int  n_acc       = 0;
   int  n_err       = 0;
   bit  acc;
   int  got;
   int  cnt;

   logic [1:0]  b_src [15] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 2, 3, 3, 3, 3};
   int          b_imm [15] = '{2047, 2048, -2048, -2049, 2047, -2049, 4094, 4095, 4096,
                               -4096, -4098, 1048574, 1048576, -1048576, -1048578};
   bit          b_err [15] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference encoder: legality via sign-extension uniformity of the upper bits.
   function automatic logic [32:0] model(input logic [1:0] s, input logic [6:0] op,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [31:0] imm);
      logic ok;
      logic [31:0] w;
      case (s)
         2'd0: begin
            ok = (imm[31:11] == '0) || (imm[31:11] == '1);
            w  = {imm[11:0], rs1, f3, rd, op};
         end
         2'd1: begin
            ok = (imm[31:11] == '0) || (imm[31:11] == '1);
            w  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
         end
         2'd2: begin
            ok = ((imm[31:12] == '0) || (imm[31:12] == '1)) && (imm[0] == 1'b0);
            w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
         end
         default: begin
            ok = ((imm[31:20] == '0) || (imm[31:20] == '1)) && (imm[0] == 1'b0);
            w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         end
      endcase
      return {!ok, w};
   endfunction

   // Sign-extender model of the core.
   function automatic logic [31:0] sext(input logic [1:0] s, input logic [31:0] i);
      case (s)
         2'd0:    return {{20{i[31]}}, i[31:20]};
         2'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
         2'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      endcase
   endfunction

   task automatic set_req(input logic [1:0] s, input logic [6:0] op, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm);
      ifc.in_src    = s;
      ifc.in_opcode = op;
      ifc.in_funct3 = f3;
      ifc.in_rd     = rd;
      ifc.in_rs1    = rs1;
      ifc.in_rs2    = rs2;
      ifc.in_imm    = imm;
   endtask

   task automatic rand_req(input int f);
      logic [31:0] r, imm;
      r = $urandom;
      case (f)
         0, 1:    imm = {{20{r[11]}}, r[11:0]};
         2:       imm = {{19{r[12]}}, r[12:1], 1'b0};
         default: imm = {{11{r[20]}}, r[20:1], 1'b0};
      endcase
      set_req(2'(f), 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              imm);
   endtask

   // One clock: check occupancy flags and head at the falling edge, record accepts.
   task automatic step(output bit accepted);
      sb_t h, e;
      accepted = 1'b0;
      @(negedge clk);
      chk("out_valid", ifc.out_valid, sb.size() != 0);
      chk("in_ready", ifc.in_ready, sb.size() < 4);
      if (ifc.out_valid === 1'b1 && ifc.out_ready && sb.size() != 0) begin
         h = sb.pop_front();
         chk("word", {ifc.out_err, ifc.out_instr}, h.word);
         if (h.rt)
            chk("roundtrip", sext(h.src, ifc.out_instr),
                h.imm & (h.src[1] ? 32'hFFFF_FFFE : 32'hFFFF_FFFF));
      end
      if (ifc.in_valid && ifc.in_ready === 1'b1) begin
         accepted = 1'b1;
         e.word = model(ifc.in_src, ifc.in_opcode, ifc.in_funct3, ifc.in_rd, ifc.in_rs1,
                        ifc.in_rs2, ifc.in_imm);
         e.imm  = ifc.in_imm;
         e.src  = ifc.in_src;
         e.rt   = !e.word[32];
         sb.push_back(e);
         n_acc++;
         if (e.word[32]) n_err++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b0;
      set_req(0, 0, 0, 0, 0, 0, 0);
      sat.in_valid  = 1'b0;
      sat.out_ready = 1'b0;
      sat.in_src    = 2'b00;
      sat.in_opcode = 7'h13;
      sat.in_funct3 = 3'd0;
      sat.in_rd     = 5'd1;
      sat.in_rs1    = 5'd0;
      sat.in_rs2    = 5'd0;
      sat.in_imm    = 32'h0000_1000;

      #12;
      chk("rst_out_valid", ifc.out_valid, 0);
      chk("rst_in_ready", ifc.in_ready, 1);
      chk("rst_out_instr", ifc.out_instr, 0);
      chk("rst_out_err", ifc.out_err, 0);
      chk("rst_enc_count", ifc.enc_count, 0);
      chk("rst_err_count", ifc.err_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // I-type, single-cycle latency then pop.
      set_req(2'b00, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
      ifc.in_valid = 1'b1;
      step(acc);
      ifc.in_valid = 1'b0;
      chk("i_latency_valid", ifc.out_valid, 1);
      chk("i_word", {ifc.out_err, ifc.out_instr}, 33'h0_FFF0_0093);
      chk("i_enc_count", ifc.enc_count, 1);
      ifc.out_ready = 1'b1;
      step(acc);
      ifc.out_ready = 1'b0;

      // B-type, legal and odd offset.
      set_req(2'b10, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
      ifc.in_valid = 1'b1;
      step(acc);
      chk("b_word", {ifc.out_err, ifc.out_instr}, 33'h0_FE20_8EE3);
      set_req(2'b10, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3);
      ifc.out_ready = 1'b1;
      step(acc);
      ifc.in_valid = 1'b0;
      chk("b_odd_err", ifc.out_err, 1);
      chk("b_err_count", ifc.err_count, 1);
      step(acc);

      // J-type, legal and just out of range.
      ifc.out_ready = 1'b0;
      set_req(2'b11, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
      ifc.in_valid = 1'b1;
      step(acc);
      chk("j_word", {ifc.out_err, ifc.out_instr}, 33'h0_0010_00EF);
      ifc.out_ready = 1'b1;
      set_req(2'b11, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1048576);
      step(acc);
      ifc.in_valid = 1'b0;
      chk("j_range_err", ifc.out_err, 1);
      chk("j_err_count", ifc.err_count, 2);
      step(acc);
      ifc.out_ready = 1'b0;

      // Range boundaries.
      for (int i = 0; i < 15; i++) begin
         set_req(b_src[i], 7'h23, 3'd2, 5'd3, 5'd4, 5'd5, b_imm[i]);
         ifc.in_valid = 1'b1;
         step(acc);
         ifc.in_valid = 1'b0;
         chk($sformatf("bound_err_%0d", i), ifc.out_err, b_err[i]);
         ifc.out_ready = 1'b1;
         step(acc);
         ifc.out_ready = 1'b0;
      end
      chk("bound_enc_count", ifc.enc_count, n_acc);
      chk("bound_err_count", ifc.err_count, n_err);

      // Backpressure: four fill the FIFO, the fifth waits for the first pop.
      ifc.in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_req(2'b00, 7'h13, 3'd0, 5'(k + 1), 5'd0, 5'd0, 32'(k));
         step(acc);
         chk("bp_accept", acc, 1);
      end
      chk("bp_full_in_ready", ifc.in_ready, 0);
      set_req(2'b00, 7'h13, 3'd0, 5'd5, 5'd0, 5'd0, 32'd4);
      step(acc);
      chk("bp_held", acc, 0);
      ifc.out_ready = 1'b1;
      step(acc);
      chk("bp_no_passthru", acc, 0);
      chk("bp_ready_after_pop", ifc.in_ready, 1);
      step(acc);
      chk("bp_fifth_accept", acc, 1);
      ifc.in_valid = 1'b0;
      for (int k = 0; k < 6; k++) step(acc);

      // Mid-stream reset with three words buffered.
      ifc.out_ready = 1'b0;
      ifc.in_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_req(2'b01, 7'h23, 3'd2, 5'd0, 5'(k), 5'(k + 7), 32'(k * 4));
         step(acc);
      end
      ifc.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", ifc.out_valid, 0);
      chk("mrst_in_ready", ifc.in_ready, 1);
      chk("mrst_out_instr", ifc.out_instr, 0);
      chk("mrst_enc_count", ifc.enc_count, 0);
      chk("mrst_err_count", ifc.err_count, 0);
      sb.delete();
      n_acc = 0;
      n_err = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      ifc.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) step(acc);

      // Random legal round-trip per format with random consumer stalls.
      for (int f = 0; f < 4; f++) begin
         got = 0;
         rand_req(f);
         ifc.in_valid = 1'b1;
         for (int k = 0; k < 40000 && got < 10000; k++) begin
            ifc.out_ready = ($urandom_range(0, 7) != 0);
            step(acc);
            if (acc) begin
               got++;
               rand_req(f);
            end
         end
         chk($sformatf("rand_accepts_fmt%0d", f), got, 10000);
      end
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) step(acc);
      chk("rand_enc_count", ifc.enc_count, (n_acc > 65535) ? 65535 : n_acc);
      chk("rand_err_count", ifc.err_count, n_err);

      // Saturation on a 4-bit-counter instance fed only illegal immediates.
      cnt = 0;
      sat.in_valid  = 1'b1;
      sat.out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (sat.in_ready === 1'b1) cnt++;
         @(posedge clk);
         #1;
         if (k == 9) chk("sat_enc_mid", sat.enc_count, (cnt > 15) ? 15 : cnt);
      end
      sat.in_valid = 1'b0;
      chk("sat_enc_count", sat.enc_count, (cnt > 15) ? 15 : cnt);
      chk("sat_err_count", sat.err_count, (cnt > 15) ? 15 : cnt);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
